// File: rtl/priority_encoder_4to2.sv
// 4-to-2 priority encoder with a valid/ready front end, a 2-entry result FIFO
// and a saturating counter of accepted words that were not one-hot.
module priority_encoder_4to2 #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           W,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           Y,
    output logic                 out_onehot,
    output logic                 out_zero,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 clr_err
);

    typedef struct packed {
        logic [1:0] y;
        logic       onehot;
        logic       zero;
    } result_t;

    result_t    enc;
    result_t    head;
    result_t    mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       err_inc;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if-chain leaves it unassigned (no latch).
        enc.y = 2'd0;
        if (W[3])      enc.y = 2'd3;
        else if (W[2]) enc.y = 2'd2;
        else if (W[1]) enc.y = 2'd1;
        enc.zero   = (W == 4'b0000);
        enc.onehot = (W != 4'b0000) && ((W & (W - 4'd1)) == 4'b0000);
    end

    // in_ready depends only on occupancy and reset, never on out_ready.
    assign in_ready  = rst_n && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign err_inc   = push && !enc.onehot;

    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign Y          = head.y;
    assign out_onehot = head.onehot;
    assign out_zero   = head.zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result storage is cleared too, so no entry captured
            // before reset can ever be presented afterwards.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments only in clocked blocks; every
            // register here sees pre-edge values of its neighbours.
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A clear that coincides with an increment leaves the counter at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= {{(ERR_CNT_W-1){1'b0}}, err_inc};
        end else if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Self-checking bench for priority_encoder_4to2: a 16-entry expectation table
// feeds a scoreboard queue that is compared against the FIFO output each cycle.
module tb_priority_encoder_4to2;

    typedef struct packed {
        logic [1:0] y;
        logic       onehot;
        logic       zero;
    } res_t;

    typedef struct {
        logic [3:0] w;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] W = 4'b0000;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;

    logic       in_ready, out_valid, out_onehot, out_zero;
    logic [1:0] Y;
    logic [7:0] err_cnt;

    logic       b_in_ready, b_out_valid, b_onehot, b_zero;
    logic [1:0] b_y;
    logic [1:0] b_err_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [16];
    res_t sb_q [$];
    int   m_err = 0;

    priority_encoder_4to2 #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .W(W), .out_valid(out_valid), .out_ready(out_ready), .Y(Y),
        .out_onehot(out_onehot), .out_zero(out_zero), .err_cnt(err_cnt),
        .clr_err(clr_err)
    );

    priority_encoder_4to2 #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .W(W), .out_valid(b_out_valid), .out_ready(out_ready), .Y(b_y),
        .out_onehot(b_onehot), .out_zero(b_zero), .err_cnt(b_err_cnt),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: outputs compared at the falling edge, then the handshakes
    // about to happen on the next rising edge update the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
            check("err_cnt", {24'd0, err_cnt}, m_err);
            check("sat_in_ready", {31'd0, b_in_ready}, {31'd0, in_ready});
            if (sb_q.size() != 0)
                check("head", {28'd0, Y, out_onehot, out_zero}, {28'd0, sb_q[0]});
            if (out_valid && out_ready && sb_q.size() != 0)
                void'(sb_q.pop_front());
            if (in_valid && in_ready) begin
                sb_q.push_back(tbl[W].exp);
                if (clr_err) m_err = tbl[W].exp.onehot ? 0 : 1;
                else if (!tbl[W].exp.onehot && m_err != 255) m_err++;
            end else if (clr_err) begin
                m_err = 0;
            end
        end
    end

    // Offer one word and return just after the edge that accepts it.
    task automatic send(input logic [3:0] w);
        logic acc = 1'b0;
        in_valid = 1'b1;
        W = w;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{w: 4'h0, exp: '{y: 2'd0, onehot: 1'b0, zero: 1'b1}};
        tbl[1]  = '{w: 4'h1, exp: '{y: 2'd0, onehot: 1'b1, zero: 1'b0}};
        tbl[2]  = '{w: 4'h2, exp: '{y: 2'd1, onehot: 1'b1, zero: 1'b0}};
        tbl[3]  = '{w: 4'h3, exp: '{y: 2'd1, onehot: 1'b0, zero: 1'b0}};
        tbl[4]  = '{w: 4'h4, exp: '{y: 2'd2, onehot: 1'b1, zero: 1'b0}};
        tbl[5]  = '{w: 4'h5, exp: '{y: 2'd2, onehot: 1'b0, zero: 1'b0}};
        tbl[6]  = '{w: 4'h6, exp: '{y: 2'd2, onehot: 1'b0, zero: 1'b0}};
        tbl[7]  = '{w: 4'h7, exp: '{y: 2'd2, onehot: 1'b0, zero: 1'b0}};
        tbl[8]  = '{w: 4'h8, exp: '{y: 2'd3, onehot: 1'b1, zero: 1'b0}};
        tbl[9]  = '{w: 4'h9, exp: '{y: 2'd3, onehot: 1'b0, zero: 1'b0}};
        tbl[10] = '{w: 4'hA, exp: '{y: 2'd3, onehot: 1'b0, zero: 1'b0}};
        tbl[11] = '{w: 4'hB, exp: '{y: 2'd3, onehot: 1'b0, zero: 1'b0}};
        tbl[12] = '{w: 4'hC, exp: '{y: 2'd3, onehot: 1'b0, zero: 1'b0}};
        tbl[13] = '{w: 4'hD, exp: '{y: 2'd3, onehot: 1'b0, zero: 1'b0}};
        tbl[14] = '{w: 4'hE, exp: '{y: 2'd3, onehot: 1'b0, zero: 1'b0}};
        tbl[15] = '{w: 4'hF, exp: '{y: 2'd3, onehot: 1'b0, zero: 1'b0}};

        // Reset state.
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_outputs", {28'd0, Y, out_onehot, out_zero}, 32'd0);
        check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        idle(1);

        // One-hot stream, one per cycle, draining as it goes.
        out_ready = 1'b1;
        send(4'b0001);
        check("lat_y0", {29'd0, out_valid, Y}, {29'd0, 1'b1, 2'd0});
        send(4'b0010);
        check("lat_y1", {29'd0, out_valid, Y}, {29'd0, 1'b1, 2'd1});
        send(4'b0100);
        check("lat_y2", {29'd0, out_valid, Y}, {29'd0, 1'b1, 2'd2});
        send(4'b1000);
        check("lat_y3", {29'd0, out_valid, Y}, {29'd0, 1'b1, 2'd3});
        idle(2);
        check("stream_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Backpressure: two accepts fill the FIFO, the third is held off.
        out_ready = 1'b0;
        send(4'b1000);
        send(4'b0100);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            W = 4'($urandom);
            @(negedge clk);
            check("full_in_ready", {31'd0, in_ready}, 32'd0);
            check("full_head_y", {30'd0, Y}, 32'd3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'b0010);
        idle(3);

        // Zero and multi-bit words.
        send(4'b0000);
        send(4'b0110);
        send(4'b1111);
        idle(3);
        check("multi_err_cnt", {24'd0, err_cnt}, 32'd3);

        // Full table through the scoreboard.
        for (int i = 0; i < 16; i++) send(tbl[i].w);
        idle(3);

        // Saturation on the 2-bit counter, clear coinciding with an increment.
        rst_n = 1'b0;
        sb_q.delete();
        m_err = 0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send(4'b0011);
        check("sat_1", {30'd0, b_err_cnt}, 32'd1);
        send(4'b0011);
        check("sat_2", {30'd0, b_err_cnt}, 32'd2);
        send(4'b0011);
        check("sat_3", {30'd0, b_err_cnt}, 32'd3);
        send(4'b0011);
        check("sat_hold", {30'd0, b_err_cnt}, 32'd3);
        clr_err = 1'b1;
        send(4'b0011);
        clr_err = 1'b0;
        check("sat_clr_inc", {30'd0, b_err_cnt}, 32'd1);
        check("wide_clr_inc", {24'd0, err_cnt}, 32'd1);
        idle(3);

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        send(4'b0101);
        send(4'b1001);
        idle(1);
        check("pre_rst_full", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        m_err = 0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("async_sat_err_cnt", {30'd0, b_err_cnt}, 32'd0);
        check("async_outputs", {28'd0, Y, out_onehot, out_zero}, 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle(3);
        send(4'b0100);
        check("post_rst_first_y", {29'd0, out_valid, Y}, {29'd0, 1'b1, 2'd2});
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/priority_encoder_4to2.md
PRIORITY_ENCODER_4TO2 -- requirements
Module: priority_encoder_4to2

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the non-one-hot error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  W carries a word to encode.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 W  input  4  4-bit word to encode (nominally one-hot).
REQ-007 out_valid  output  1  Y/out_onehot/out_zero hold a result.
REQ-008 out_ready  input  1  downstream consumes the result this cycle.
REQ-009 Y  output  2  binary index of the highest set bit of the accepted W.
REQ-010 out_onehot  output  1  the accepted W had exactly one bit set.
REQ-011 out_zero  output  1  the accepted W was 4'b0000.
REQ-012 err_cnt  output  ERR_CNT_W  saturating count of accepted non-one-hot words.
REQ-013 clr_err  input  1  synchronous clear of err_cnt.

Function
REQ-014 Accept occurs when in_valid=1 and in_ready=1 on a rising edge; push occurs only on accept.
REQ-015 Pop occurs when out_valid=1 and out_ready=1 on a rising edge.
REQ-016 Results are held in a 2-entry FIFO of {Y, out_onehot, out_zero}; occupancy 0, 1 or 2.
REQ-017 in_ready=1 when occupancy <2, else 0; no combinational path from out_ready to in_ready.
REQ-018 Push and pop in the same cycle leave occupancy unchanged; at occupancy 2 no push occurs (in_ready=0).
REQ-019 out_valid=1 when occupancy >0; Y/out_onehot/out_zero present the oldest entry.
REQ-020 Latency: a word accepted at edge N appears on outputs after edge N (one cycle); no same-cycle pass-through.
REQ-021 Outputs are stable while out_valid=1 and out_ready=0.
REQ-022 Encoding priority: W[3] -> Y=3; else W[2] -> 2; else W[1] -> 1; else Y=0.
REQ-023 out_zero=1 iff W=0000, with Y=0 in that case; out_onehot=1 iff popcount(W)=1.
REQ-024 Entries leave in acceptance order; no entry is dropped or duplicated.
REQ-025 err_cnt increments by 1 on each accept with popcount(W)!=1 (zero included).
REQ-026 err_cnt saturates at all-ones and holds there.
REQ-027 clr_err=1 sets err_cnt to 0; if an increment coincides, err_cnt becomes 1.
REQ-028 W is ignored when no accept occurs; in_valid without in_ready changes no state.

Reset
REQ-029 rst_n=0 immediately empties the FIFO, forcing out_valid=0, Y=0, out_onehot=0, out_zero=0 and err_cnt=0, independent of clk.
REQ-030 in_ready=0 while rst_n=0; in_ready=1 from the first cycle after rst_n rises.
REQ-031 Reset mid-transfer discards all held entries; no result from before reset appears afterward.

Verification
REQ-032 Reset release, out_ready=1, then stream W=0001, 0010, 0100 and 1000 at one per cycle -> Y=0,1,2,3 in order, each one cycle after accept, out_onehot=1, err_cnt=0.
REQ-033 out_ready=0, offer W=1000, 0100, 0010 back-to-back -> in_ready drops after 2 accepts, third held off; raise out_ready -> Y=3,2 then 1.
REQ-034 Accept W=0000, 0110 and 1111 -> Y=0/out_zero=1, Y=2/out_onehot=0, Y=3/out_onehot=0; err_cnt=3.
REQ-035 ERR_CNT_W=2, accept 5 words of 0011 with clr_err=1 on the 5th -> err_cnt 1,2,3,3 then 1.
REQ-036 FIFO holding 2 entries with out_valid=1, assert rst_n=0 between edges -> out_valid=0 and err_cnt=0 immediately; after release in_ready=1 and no stale results appear.
